// File: rtl/m68k_bus_arbiter.sv
// 68000-side bus arbiter: owns BG_n, services DMA BR_n/BGACK_n requests and
// gates new CPU bus cycles through cyc_grant. Also counts DMA takeovers.
module m68k_bus_arbiter #(
    parameter int GRANT_TIMEOUT  = 16,
    parameter int RECLAIM_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic             M68K_CLK,
    input  logic             M68K_RESET_n,
    input  logic             M68K_BR_n,
    input  logic             M68K_BGACK_n,
    input  logic             cyc_start,
    input  logic             cyc_active,
    output logic             M68K_BG_n,
    output logic             cyc_grant,
    output logic             dma_active,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] grant_count,
    output logic [2:0]       state_dbg
);

    localparam int MAX_CYC = (GRANT_TIMEOUT > RECLAIM_CYCLES) ? GRANT_TIMEOUT : RECLAIM_CYCLES;
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] GRANT_LAST   = CW'(GRANT_TIMEOUT - 1);
    localparam logic [CW-1:0] RECLAIM_LAST = CW'(RECLAIM_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_END = 3'd1,
        GRANT    = 3'd2,
        OWNED    = 3'd3,
        RECLAIM  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          timeout_next;

    // Raw active-low flops; idle (reset) level is 1 so nothing looks requested.
    logic br_meta, br_sync, bgack_meta, bgack_sync;
    logic br_s, bgack_s;

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            br_meta    <= 1'b1;
            br_sync    <= 1'b1;
            bgack_meta <= 1'b1;
            bgack_sync <= 1'b1;
        end else begin
            br_meta    <= M68K_BR_n;
            br_sync    <= br_meta;
            bgack_meta <= M68K_BGACK_n;
            bgack_sync <= bgack_meta;
        end
    end

    assign br_s    = !br_sync;
    assign bgack_s = !bgack_sync;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (br_s) begin
                    // A cycle starting on the same clock as the request wins.
                    state_next = (cyc_active || cyc_start) ? WAIT_END : GRANT;
                    cnt_next   = '0;
                end
            end
            WAIT_END: begin
                if (!br_s) begin
                    state_next = IDLE;
                end else if (!cyc_active && !cyc_start) begin
                    state_next = GRANT;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                if (bgack_s) begin
                    state_next = OWNED;
                end else if (!br_s) begin
                    state_next = IDLE;
                end else if (cnt == GRANT_LAST) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            OWNED: begin
                if (!bgack_s) begin
                    state_next = RECLAIM;
                    cnt_next   = '0;
                end
            end
            RECLAIM: begin
                if (cnt == RECLAIM_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state         <= IDLE;
            cnt           <= '0;
            M68K_BG_n     <= 1'b1;
            cyc_grant     <= 1'b1;
            dma_active    <= 1'b0;
            timeout_pulse <= 1'b0;
            grant_count   <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            M68K_BG_n     <= (state_next != GRANT);
            cyc_grant     <= (state_next == IDLE);
            dma_active    <= (state_next == OWNED);
            timeout_pulse <= timeout_next;
            if (state_next == OWNED && state != OWNED) begin
                grant_count <= grant_count + CNT_W'(1);
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
Bus-arbitration stage on the 68000 side, next to the PiStorm bus-cycle state machine. It owns M68K_BG_n, services Amiga DMA bus requests (BR_n/BGACK_n), and tells the cycle state machine when it may start a new cycle (cyc_grant). It also reports DMA ownership and grant statistics for the status register.

Parameters:
GRANT_TIMEOUT, 16, M68K_CLK cycles BG_n may stay asserted without BGACK_n before the grant is withdrawn (≥2)
RECLAIM_CYCLES, 2, M68K_CLK cycles after BGACK_n negates before cyc_grant is re-asserted (≥1)
CNT_W, 16, width of grant_count

Ports:
M68K_CLK  in  1  7 MHz 68000 clock; all logic on rising edge
M68K_RESET_n  in  1  asynchronous active-low reset
M68K_BR_n  in  1  bus request from DMA master, asynchronous
M68K_BGACK_n  in  1  bus-grant acknowledge from DMA master, asynchronous
cyc_start  in  1  one-cycle pulse: cycle state machine leaves idle this clock
cyc_active  in  1  high while our cycle drives AS_n (S2..S7)
M68K_BG_n  out  1  bus grant to DMA master, active low
cyc_grant  out  1  high: cycle state machine may issue cyc_start
dma_active  out  1  high while DMA master owns the bus
timeout_pulse  out  1  one-clock pulse when a grant times out
grant_count  out  CNT_W  number of completed BGACK takeovers, wraps

Behaviour:
- BR_n, BGACK_n each pass a 2-flop synchronizer (reset to 1); br_s = !BR_n synced, bgack_s = !BGACK_n synced. 2-clock input latency.
- All outputs registered. Reset values: M68K_BG_n=1, cyc_grant=1, dma_active=0, timeout_pulse=0, grant_count=0, state=IDLE, counter=0.
- States: IDLE, WAIT_END, GRANT, OWNED, RECLAIM.
- IDLE: BG_n=1, cyc_grant=1. If br_s: go WAIT_END when cyc_active or cyc_start is high this clock, else GRANT. cyc_grant drops on the same edge as leaving IDLE.
- Simultaneous cyc_start and first br_s: our cycle wins, go WAIT_END.
- WAIT_END: cyc_grant=0. If !br_s, return to IDLE. Else if !cyc_active and !cyc_start, go GRANT.
- GRANT: BG_n=0, counter increments each clock from 0. Priority order:
  - bgack_s: go OWNED.
  - else !br_s: go IDLE (request withdrawn).
  - else counter==GRANT_TIMEOUT-1: go IDLE and pulse timeout_pulse.
  - BG_n returns to 1 on the edge leaving GRANT.
- OWNED: BG_n=1, dma_active=1, cyc_grant=0. grant_count increments by 1 on entry (mod 2^CNT_W). When !bgack_s, go RECLAIM with counter=0; br_s is ignored while in OWNED.
- RECLAIM: dma_active=0, cyc_grant=0. Counter increments. At counter==RECLAIM_CYCLES-1, go IDLE (cyc_grant=1 next edge). If br_s is still set, IDLE re-arbitrates on the following clock.
- cyc_start while cyc_grant=0 is illegal. The arbiter ignores it except in the IDLE/WAIT_END decision above.
- M68K_RESET_n asserted mid-operation: immediately forces reset values, including BG_n=1 asynchronously. No grant survives reset.
- Counter width: clog2(max(GRANT_TIMEOUT, RECLAIM_CYCLES)); it never wraps within a state.

Test Plan:
- Idle grant: BR_n falls with cyc_active=0 → BG_n low 3 clocks later (2 sync + 1), cyc_grant low the same edge. BGACK_n low → BG_n high 3 clocks later, dma_active=1, grant_count=1.
- Cycle in flight: BR_n low while cyc_active=1 for 6 clocks → BG_n stays 1 until the clock after cyc_active falls, then 0.
- Withdrawn request: BR_n low then high after BG_n asserts, BGACK_n never asserted → BG_n high 3 clocks after BR_n rises, cyc_grant back to 1, timeout_pulse never fires, grant_count unchanged.
- Timeout: BR_n held low, BGACK_n high → BG_n low exactly 16 clocks, one timeout_pulse, then re-grant after 2 clocks in IDLE/WAIT path.
- Reclaim: BGACK_n rises after a 20-clock DMA → dma_active 0 after sync, cyc_grant 1 after exactly RECLAIM_CYCLES=2 further clocks, then cyc_start accepted.
- Reset mid-grant: assert M68K_RESET_n low while BG_n=0 → BG_n=1 before the next clock edge. After release, state IDLE, cyc_grant=1, grant_count=0. Also wrap check: CNT_W=2, 5 takeovers → grant_count=1.
